// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and secondary (mul/div) results
// queue in a FIFO that drains in pipeline bubbles, with a one-cycle forced stall to bound their wait.
module rf_wport_arb #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_we_i,
  input  logic [4:0]               pipe_waddr_i,
  input  logic [31:0]              pipe_wdata_i,
  output logic                     pipe_stall_o,
  input  logic                     sec_valid_i,
  input  logic [4:0]               sec_waddr_i,
  input  logic [31:0]              sec_wdata_i,
  output logic                     sec_ready_o,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic                     rf_src_o,
  output logic [$clog2(DEPTH):0]   pend_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic [GW-1:0] age, age_next;

  logic pipe_req, drain, enq, full, stall_set;

  assign full        = (count == CW'(DEPTH));
  assign sec_ready_o = !full;
  assign pend_cnt_o  = count;

  // A stalled pipeline's wb inputs are stale, so they never win the port.
  assign pipe_req  = pipe_we_i && (pipe_waddr_i != 5'd0) && !pipe_stall_o;
  assign enq       = sec_valid_i && sec_ready_o && (sec_waddr_i != 5'd0);
  assign drain     = (count != '0) && !pipe_req;
  assign stall_set = (age == GW'(STARVE_LIMIT - 1)) && !drain && !pipe_stall_o;

  always_comb begin
    count_next = count;
    case ({enq, drain})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    age_next = age;
    if (count == '0 || drain)
      age_next = '0;
    else if (age != GW'(STARVE_LIMIT))
      age_next = age + GW'(1);
  end

  // Storage needs no reset: entries are only ever read while count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= sec_waddr_i;
      data_mem[tail] <= sec_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      age          <= '0;
      pipe_stall_o <= 1'b0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= 5'd0;
      rf_wdata_o   <= 32'd0;
      rf_src_o     <= 1'b0;
    end else begin
      count        <= count_next;
      age          <= age_next;
      pipe_stall_o <= stall_set;
      if (enq)
        tail <= tail + AW'(1);
      if (pipe_req) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= pipe_waddr_i;
        rf_wdata_o <= pipe_wdata_i;
        rf_src_o   <= 1'b0;
      end else if (drain) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= addr_mem[head];
        rf_wdata_o <= data_mem[head];
        rf_src_o   <= 1'b1;
        head       <= head + AW'(1);
      end else begin
        rf_we_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: directed table, hand-written corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_rf_wport_arb;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we_i = 1'b0;
  logic [4:0]  pipe_waddr_i = '0;
  logic [31:0] pipe_wdata_i = '0;
  logic        pipe_stall_o;
  logic        sec_valid_i = 1'b0;
  logic [4:0]  sec_waddr_i = '0;
  logic [31:0] sec_wdata_i = '0;
  logic        sec_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_src_o;
  logic [2:0]  pend_cnt_o;

  rf_wport_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .pipe_stall_o(pipe_stall_o),
    .sec_valid_i(sec_valid_i), .sec_waddr_i(sec_waddr_i), .sec_wdata_i(sec_wdata_i),
    .sec_ready_o(sec_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_src_o(rf_src_o), .pend_cnt_o(pend_cnt_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending secondary results as a queue, plus the visible registers.
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  int          m_age;
  logic        m_stall, m_we, m_src;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    mq.delete();
    m_age = 0; m_stall = 0; m_we = 0; m_src = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit   preq, drain, enq, stall_nx;
    ent_t e;
    int   n;
    n        = mq.size();
    preq     = pipe_we_i && pipe_waddr_i != 0 && !m_stall;
    drain    = (n != 0) && !preq;
    enq      = sec_valid_i && (n < DEPTH) && sec_waddr_i != 0;
    stall_nx = (m_age == LIMIT - 1) && !drain && !m_stall;
    if (preq) begin
      m_we = 1; m_addr = pipe_waddr_i; m_data = pipe_wdata_i; m_src = 0;
    end else if (drain) begin
      e = mq.pop_front();
      m_we = 1; m_addr = e.a; m_data = e.d; m_src = 1;
    end else begin
      m_we = 0;
    end
    if (n == 0 || drain) m_age = 0;
    else if (m_age < LIMIT) m_age = m_age + 1;
    m_stall = stall_nx;
    if (enq) begin
      e.a = sec_waddr_i; e.d = sec_wdata_i;
      mq.push_back(e);
    end
  endtask

  function automatic logic [43:0] dut_vec();
    return {rf_we_o, rf_waddr_o, rf_wdata_o, rf_src_o, pipe_stall_o, pend_cnt_o, sec_ready_o};
  endfunction

  function automatic logic [43:0] model_vec();
    return {m_we, m_addr, m_data, m_src, m_stall, 3'(mq.size()), 1'(mq.size() < DEPTH)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(string name);
    model_step();
    @(posedge clk); #1;
    check(name, 64'(dut_vec()), 64'(model_vec()));
  endtask

  task automatic idle_inputs();
    pipe_we_i = 0; pipe_waddr_i = '0; pipe_wdata_i = '0;
    sec_valid_i = 0; sec_waddr_i = '0; sec_wdata_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check("reset_state", 64'(dut_vec()), 64'({1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1}));
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    logic pwe; logic [4:0] pa; logic [31:0] pd;
    logic sv;  logic [4:0] sa; logic [31:0] sd;
    logic ewe; logic [4:0] ea; logic [31:0] ed; logic esrc; logic [2:0] ecnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int   stall_cnt, first_stall, sec_at, idx, acc_at, maxcnt, wr_cnt, have;
    bit   saw_full;
    ent_t got[$];
    ent_t g;
    logic [4:0]  sec_a;
    logic [31:0] sec_d;

    // Expected registered outputs after each row's clock edge.
    tbl[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 5'd5, 32'hDEADBEEF, 0, 3'd0};
    tbl[1] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd5, 32'hDEADBEEF, 0, 3'd0};
    tbl[2] = '{0, 5'd0, 32'h0,        1, 5'd3, 32'h11, 0, 5'd5, 32'hDEADBEEF, 0, 3'd1};
    tbl[3] = '{0, 5'd0, 32'h0,        1, 5'd4, 32'h22, 1, 5'd3, 32'h11,       1, 3'd1};
    tbl[4] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd4, 32'h22,       1, 3'd0};
    tbl[5] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd4, 32'h22,       1, 3'd0};
    tbl[6] = '{1, 5'd0, 32'h55,       1, 5'd0, 32'h66, 0, 5'd4, 32'h22,       1, 3'd0};
    tbl[7] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd4, 32'h22,       1, 3'd0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      pipe_we_i = tbl[i].pwe; pipe_waddr_i = tbl[i].pa; pipe_wdata_i = tbl[i].pd;
      sec_valid_i = tbl[i].sv; sec_waddr_i = tbl[i].sa; sec_wdata_i = tbl[i].sd;
      step($sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d_expect", i), 64'(dut_vec()),
            64'({tbl[i].ewe, tbl[i].ea, tbl[i].ed, tbl[i].esrc, 1'b0, tbl[i].ecnt, 1'b1}));
    end

    // Starvation: pipeline busy every cycle, one secondary result at cycle 0.
    do_reset();
    stall_cnt = 0; first_stall = -1; sec_at = -1; sec_a = '0; sec_d = '0;
    for (int k = 0; k < 14; k++) begin
      pipe_we_i = 1; pipe_waddr_i = 5'd7; pipe_wdata_i = 32'(k);
      sec_valid_i = (k == 0); sec_waddr_i = 5'd9; sec_wdata_i = 32'hABCD0009;
      step("starve_model");
      if (pipe_stall_o) begin
        stall_cnt++;
        if (first_stall < 0) first_stall = k;
      end
      if (rf_we_o && rf_src_o && sec_at < 0) begin
        sec_at = k; sec_a = rf_waddr_o; sec_d = rf_wdata_o;
      end
    end
    check("starve_stall_count", 64'(stall_cnt), 64'd1);
    check("starve_stall_cycle", 64'(first_stall), 64'd8);
    check("starve_sec_cycle", 64'(sec_at), 64'd9);
    check("starve_sec_write", {27'd0, sec_a, sec_d}, {27'd0, 5'd9, 32'hABCD0009});

    // Full FIFO: pipeline busy, five results offered back to back.
    do_reset();
    idx = 0; acc_at = -1; maxcnt = 0; saw_full = 0;
    got.delete();
    for (int k = 0; k < 70; k++) begin
      pipe_we_i = 1; pipe_waddr_i = 5'd7; pipe_wdata_i = 32'h7000 + 32'(k);
      sec_valid_i = (idx < 5); sec_waddr_i = 5'(10 + idx); sec_wdata_i = 32'h100 + 32'(idx);
      #1;
      if (sec_valid_i && sec_ready_o) begin
        if (idx == 4) acc_at = k;
        idx++;
      end
      step("full_model");
      if (32'(pend_cnt_o) > maxcnt) maxcnt = 32'(pend_cnt_o);
      if (pend_cnt_o == 3'd4 && !sec_ready_o) saw_full = 1;
      if (rf_we_o && rf_src_o) begin
        g.a = rf_waddr_o; g.d = rf_wdata_o;
        got.push_back(g);
      end
    end
    check("full_accepted", 64'(idx), 64'd5);
    check("full_max_cnt", 64'(maxcnt), 64'd4);
    check("full_not_ready", 64'(saw_full), 64'd1);
    check("full_fifth_accept", 64'(acc_at), 64'd10);
    check("full_writes", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      check($sformatf("full_order%0d", i), {27'd0, got[i].a, got[i].d},
            {27'd0, 5'(10 + i), 32'h100 + 32'(i)});

    // Reset with three entries pending.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pipe_we_i = 1; pipe_waddr_i = 5'd7; pipe_wdata_i = 32'(k);
      sec_valid_i = 1; sec_waddr_i = 5'(20 + k); sec_wdata_i = 32'h200 + 32'(k);
      step("prerst_model");
    end
    check("prerst_cnt", 64'(pend_cnt_o), 64'd3);
    #2 rst_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check("midrst_state", 64'(dut_vec()), 64'({1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1}));
    @(posedge clk); #1 rst_n = 1;
    wr_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step("postrst_model");
      if (rf_we_o) wr_cnt++;
    end
    check("postrst_no_writes", 64'(wr_cnt), 64'd0);

    // Randomized traffic in phases of light and heavy pipeline load.
    do_reset();
    have = 0;
    for (int k = 0; k < 600; k++) begin
      pipe_we_i    = ($urandom_range(0, 99) < (((k / 100) % 2 == 0) ? 92 : 35));
      pipe_waddr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_wdata_i = $urandom;
      if (have == 0 && $urandom_range(0, 1) == 1) begin
        have = 1;
        sec_waddr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        sec_wdata_i = $urandom;
      end
      sec_valid_i = (have != 0);
      if (have != 0 && mq.size() < DEPTH) have = 0;
      step("rand_model");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
